sram_port_arbiter: RTL and testbench

- Shares one single-port, byte-masked, 1-cycle-read-latency SRAM macro (RW0-style: en/wmode/addr/wmask/wdata → registered rdata) between two requesters, A (core load/store) and B (DMA/debug).
- Round-robin arbitration, valid/ready request channels, fixed-latency read response.
- Sits between the tightly-coupled-memory front end and the SRAM macro instance.

---
 rtl/sram_arb_pkg.sv | 26 ++
 rtl/sram_rr_grant2.sv | 49 ++++
 rtl/sram_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: request struct, arbiter states, grant encoding.
// The request struct is width-generic through SRAM_ARB_REQ_T; sram_req_t is the default-width instance.
`define SRAM_ARB_REQ_T(AW, DW) struct packed { \
  logic                write; \
  logic [(AW)-1:0]     addr; \
  logic [(DW)/8-1:0]   wmask; \
  logic [(DW)-1:0]     wdata; \
}

package sram_arb_pkg;

  localparam int ARB_ADDR_W_DFLT = 12;
  localparam int ARB_DATA_W_DFLT = 32;

  typedef `SRAM_ARB_REQ_T(ARB_ADDR_W_DFLT, ARB_DATA_W_DFLT) sram_req_t;

  typedef enum logic {
    ARB_INIT = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_e;

  // Grant / pointer encoding shared by all round-robin users
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/sram_rr_grant2.sv
// Two-way round-robin grant: the pointer names the side that wins a contended cycle.
module sram_rr_grant2
  import sram_arb_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic gnt_any,
  output logic gnt_sel
);

  logic ptr_r;
  logic contended_s;

  // Grant decode for the current cycle
  always_comb begin
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    contended_s = enable & req_a & req_b;
    if (!enable) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end else if (req_a && req_b) begin
      gnt_a = (ptr_r == GNT_A);
      gnt_b = (ptr_r == GNT_B);
    end else begin
      gnt_a = req_a;
      gnt_b = req_b;
    end
    gnt_any = gnt_a | gnt_b;
    gnt_sel = gnt_b ? GNT_B : GNT_A;
  end

  // Pointer hands priority to the loser after contention only
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= GNT_A;
    end else if (contended_s) begin
      ptr_r <= ~ptr_r;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port byte-masked SRAM macro between requesters A and B (round-robin).
// Build option SRAM_ZERO_INIT_EN: zero the whole macro after reset before accepting requests.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter  int ADDR_W = 12,
  parameter  int DATA_W = 32,
  localparam int MASK_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_write,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [MASK_W-1:0] a_req_wmask,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_write,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [MASK_W-1:0] b_req_wmask,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              init_done
);

  typedef `SRAM_ARB_REQ_T(ADDR_W, DATA_W) req_t;
  localparam int REQ_W = $bits(req_t);

  req_t a_req_s, b_req_s, mux_s, hold_r;
  logic gnt_a_s, gnt_b_s, gnt_any_s, gnt_sel_s;
  logic a_rsp_valid_r, b_rsp_valid_r;

  assign a_req_s = '{write: a_req_write, addr: a_req_addr, wmask: a_req_wmask, wdata: a_req_wdata};
  assign b_req_s = '{write: b_req_write, addr: b_req_addr, wmask: b_req_wmask, wdata: b_req_wdata};

  sram_rr_grant2 u_grant (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (init_done),
    .req_a   (a_req_valid),
    .req_b   (b_req_valid),
    .gnt_a   (gnt_a_s),
    .gnt_b   (gnt_b_s),
    .gnt_any (gnt_any_s),
    .gnt_sel (gnt_sel_s)
  );

`ifdef SRAM_ZERO_INIT_EN
  arb_state_e      state_r, state_nxt_s;
  logic [ADDR_W:0] cnt_r, cnt_nxt_s;

  // Fill state and counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ARB_INIT;
      cnt_r   <= {(ADDR_W+1){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // One write per cycle; the extra counter bit flags the pass over the last address
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ARB_INIT: begin
        cnt_nxt_s = cnt_r + {{ADDR_W{1'b0}}, 1'b1};
        if (cnt_nxt_s[ADDR_W]) begin
          state_nxt_s = ARB_RUN;
        end else begin
          state_nxt_s = ARB_INIT;
        end
      end
      ARB_RUN: begin
        state_nxt_s = ARB_RUN;
        cnt_nxt_s   = cnt_r;
      end
      default: begin
        state_nxt_s = ARB_INIT;
        cnt_nxt_s   = {(ADDR_W+1){1'b0}};
      end
    endcase
  end

  assign init_done = (state_r == ARB_RUN);
`else
  assign init_done = 1'b1;
`endif

  // Macro command: fill pattern, granted request, or the previous command held
  always_comb begin
    mux_s   = hold_r;
    sram_en = 1'b0;
`ifdef SRAM_ZERO_INIT_EN
    if (state_r == ARB_INIT) begin
      mux_s   = '{write: 1'b1, addr: cnt_r[ADDR_W-1:0], wmask: {MASK_W{1'b1}}, wdata: {DATA_W{1'b0}}};
      sram_en = 1'b1;
    end else
`endif
    if (gnt_any_s) begin
      mux_s       = (gnt_sel_s == GNT_B) ? b_req_s : a_req_s;
      mux_s.wmask = mux_s.write ? mux_s.wmask : {MASK_W{1'b0}};
      sram_en     = 1'b1;
    end else begin
      mux_s   = hold_r;
      sram_en = 1'b0;
    end
  end

  // Last issued command, so idle cycles do not toggle the macro inputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_r <= {REQ_W{1'b0}};
    end else begin
      hold_r <= mux_s;
    end
  end

  // Read response strobes, one cycle after the read handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_rsp_valid_r <= 1'b0;
      b_rsp_valid_r <= 1'b0;
    end else begin
      a_rsp_valid_r <= a_req_valid & gnt_a_s & ~a_req_write;
      b_rsp_valid_r <= b_req_valid & gnt_b_s & ~b_req_write;
    end
  end

  assign a_req_ready = gnt_a_s;
  assign b_req_ready = gnt_b_s;
  assign a_rsp_valid = a_rsp_valid_r;
  assign b_rsp_valid = b_rsp_valid_r;
  assign a_rsp_rdata = sram_rdata;
  assign b_rsp_rdata = sram_rdata;

  assign sram_wmode = mux_s.write;
  assign sram_addr  = mux_s.addr;
  assign sram_wmask = mux_s.wmask;
  assign sram_wdata = mux_s.wdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1-cycle-latency byte-masked SRAM.
// Follows SRAM_ZERO_INIT_EN when the design is built with it.
module tb_sram_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;
`ifdef SRAM_ZERO_INIT_EN
  localparam logic ZI = 1'b1;
`else
  localparam logic ZI = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              a_req_valid, a_req_ready, a_req_write;
  logic [ADDR_W-1:0] a_req_addr;
  logic [MASK_W-1:0] a_req_wmask;
  logic [DATA_W-1:0] a_req_wdata, a_rsp_rdata;
  logic              a_rsp_valid;
  logic              b_req_valid, b_req_ready, b_req_write;
  logic [ADDR_W-1:0] b_req_addr;
  logic [MASK_W-1:0] b_req_wmask;
  logic [DATA_W-1:0] b_req_wdata, b_rsp_rdata;
  logic              b_rsp_valid;
  logic              sram_en, sram_wmode, init_done;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;

  logic [DATA_W-1:0] mem [DEPTH];
  int checks = 0;
  int errors = 0;
  logic [3:0] gnt_b_tbl, arsp_tbl, brsp_tbl;

  always #5 clock = ~clock;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
    .a_req_addr(a_req_addr), .a_req_wmask(a_req_wmask), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
    .b_req_addr(b_req_addr), .b_req_wmask(b_req_wmask), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .init_done(init_done)
  );

  // SRAM macro model: byte-masked write, registered read
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int i = 0; i < MASK_W; i++)
          if (sram_wmask[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic w, input logic [ADDR_W-1:0] ad,
                         input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
    a_req_valid = v; a_req_write = w; a_req_addr = ad; a_req_wmask = m; a_req_wdata = d;
  endtask

  task automatic drive_b(input logic v, input logic w, input logic [ADDR_W-1:0] ad,
                         input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d);
    b_req_valid = v; b_req_write = w; b_req_addr = ad; b_req_wmask = m; b_req_wdata = d;
  endtask

  task automatic idle_all();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
`ifdef SRAM_ZERO_INIT_EN
    drive_a(1'b1, 1'b0, 12'h009, 4'hF, 32'h0);
    drive_b(1'b1, 1'b0, 12'h00A, 4'hF, 32'h0);
    for (int k = 0; k < DEPTH; k++) begin
      #2;
      if (k == 0 || k == 9 || k == DEPTH - 1) begin
        check_val("init_a_ready", a_req_ready, 0);
        check_val("init_b_ready", b_req_ready, 0);
        check_val("init_en", sram_en, 1);
        check_val("init_wmode", sram_wmode, 1);
        check_val("init_addr", sram_addr, k);
        check_val("init_wmask", sram_wmask, 4'hF);
        check_val("init_wdata", sram_wdata, 0);
        check_val("init_done_low", init_done, 0);
      end
      step();
    end
    idle_all();
    #2;
    check_val("init_done_high", init_done, 1);
`endif
  endtask

  initial begin
    gnt_b_tbl = 4'b1010;
    arsp_tbl  = 4'b1010;
    brsp_tbl  = 4'b0100;
    idle_all();
    drive_a(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
    drive_b(1'b0, 1'b0, 12'h000, 4'h0, 32'h0);
    step(); step(); #2;
    check_val("rst_a_rsp_valid", a_rsp_valid, 0);
    check_val("rst_b_rsp_valid", b_rsp_valid, 0);
    check_val("rst_init_done", init_done, !ZI);
    check_val("rst_sram_en", sram_en, 0);
    release_reset();

    // Masked write then read-back
    step(); drive_a(1'b1, 1'b1, 12'h010, 4'hF, 32'h5566_7788); #2;
    check_val("pre_a_ready", a_req_ready, 1);
    step(); drive_a(1'b1, 1'b1, 12'h010, 4'b0011, 32'h0000_1234); #2;
    check_val("wr_en", sram_en, 1);
    check_val("wr_wmode", sram_wmode, 1);
    check_val("wr_wmask", sram_wmask, 4'b0011);
    check_val("wr_addr", sram_addr, 12'h010);
    check_val("wr_wdata", sram_wdata, 32'h0000_1234);
    step(); drive_a(1'b1, 1'b0, 12'h010, 4'hF, 32'hFFFF_FFFF); #2;
    check_val("wr_no_rsp", a_rsp_valid, 0);
    check_val("rd_wmode", sram_wmode, 0);
    check_val("rd_wmask_forced", sram_wmask, 0);
    step(); idle_all(); #2;
    check_val("rd_rsp_valid", a_rsp_valid, 1);
    check_val("rd_rdata", a_rsp_rdata, 32'h5566_1234);
    check_val("rd_b_quiet", b_rsp_valid, 0);
    check_val("idle_en", sram_en, 0);
    check_val("idle_addr_hold", sram_addr, 12'h010);
    step(); #2;
    check_val("rsp_pulse", a_rsp_valid, 0);

    // Contention: alternate A, B, A, B
    step(); drive_a(1'b1, 1'b1, 12'h001, 4'hF, 32'h1111_1111); #2;
    step(); idle_all(); drive_b(1'b1, 1'b1, 12'h002, 4'hF, 32'h2222_2222); #2;
    check_val("b_only_ready", b_req_ready, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      drive_a(1'b1, 1'b0, 12'h001, 4'h0, 32'h0);
      drive_b(1'b1, 1'b0, 12'h002, 4'h0, 32'h0);
      #2;
      check_val("rr_a_ready", a_req_ready, !gnt_b_tbl[k]);
      check_val("rr_b_ready", b_req_ready, gnt_b_tbl[k]);
      check_val("rr_addr", sram_addr, gnt_b_tbl[k] ? 12'h002 : 12'h001);
      check_val("rr_a_rsp", a_rsp_valid, arsp_tbl[k]);
      check_val("rr_b_rsp", b_rsp_valid, brsp_tbl[k]);
      if (arsp_tbl[k]) check_val("rr_a_rdata", a_rsp_rdata, 32'h1111_1111);
      if (brsp_tbl[k]) check_val("rr_b_rdata", b_rsp_rdata, 32'h2222_2222);
    end
    step(); idle_all(); #2;
    check_val("rr_last_a_rsp", a_rsp_valid, 0);
    check_val("rr_last_b_rsp", b_rsp_valid, 1);
    check_val("rr_last_b_rdata", b_rsp_rdata, 32'h2222_2222);

    // B write immediately followed by A read of the same word
    step(); drive_b(1'b1, 1'b1, 12'h7FF, 4'hF, 32'hDEAD_BEEF); #2;
    check_val("raw_b_ready", b_req_ready, 1);
    step(); idle_all(); drive_a(1'b1, 1'b0, 12'h7FF, 4'h0, 32'h0); #2;
    check_val("raw_a_ready", a_req_ready, 1);
    step(); idle_all(); #2;
    check_val("raw_a_rsp", a_rsp_valid, 1);
    check_val("raw_rdata", a_rsp_rdata, 32'hDEAD_BEEF);
    check_val("raw_b_rsp", b_rsp_valid, 0);

    // Write with an empty byte mask leaves the word intact
    step(); drive_a(1'b1, 1'b1, 12'h020, 4'hF, 32'hA5A5_A5A5); #2;
    step(); drive_a(1'b1, 1'b1, 12'h020, 4'h0, 32'hFFFF_FFFF); #2;
    check_val("m0_en", sram_en, 1);
    check_val("m0_wmode", sram_wmode, 1);
    check_val("m0_wmask", sram_wmask, 0);
    step(); drive_a(1'b1, 1'b0, 12'h020, 4'h0, 32'h0); #2;
    step(); idle_all(); #2;
    check_val("m0_rsp", a_rsp_valid, 1);
    check_val("m0_rdata", a_rsp_rdata, 32'hA5A5_A5A5);

    // Reset during an in-flight read; pointer was left on B
    step(); drive_a(1'b1, 1'b1, 12'h009, 4'hF, 32'h0BAD_F00D); #2;
    step();
    drive_a(1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
    drive_b(1'b1, 1'b0, 12'h001, 4'h0, 32'h0);
    #2;
    check_val("pre_rst_a_grant", a_req_ready, 1);
    step(); reset_n = 1'b0; idle_all(); #1;
    check_val("rst_drop_rsp", a_rsp_valid, 0);
    step(); #2;
    check_val("rst_hold_a_rsp", a_rsp_valid, 0);
    check_val("rst_hold_b_rsp", b_rsp_valid, 0);
    release_reset();
    step();
    drive_a(1'b1, 1'b0, 12'h001, 4'h0, 32'h0);
    drive_b(1'b1, 1'b0, 12'h002, 4'h0, 32'h0);
    #2;
    check_val("post_rst_a_grant", a_req_ready, 1);
    check_val("post_rst_b_wait", b_req_ready, 0);
    step(); idle_all(); drive_a(1'b1, 1'b0, 12'h009, 4'h0, 32'h0); #2;
    check_val("post_rst_rsp", a_rsp_valid, 1);
    check_val("post_rst_rdata", a_rsp_rdata, ZI ? 32'h0 : 32'h1111_1111);
    step(); idle_all(); #2;
    check_val("addr9_rsp", a_rsp_valid, 1);
    check_val("addr9_rdata", a_rsp_rdata, ZI ? 32'h0 : 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
